// File: rtl/sht40_result_converter.sv
// sht40_result_converter
// Converts raw SHT40 temperature/humidity ticks into centi-degC and centi-%RH.
// A single shift-add multiplier is time-shared: 16 cycles for temperature,
// then 16 cycles for humidity, then one cycle to publish the pair.
module sht40_result_converter #(
  parameter int T_SCALE     = 17500,
  parameter int T_OFFSET    = 4500,
  parameter int RH_SCALE    = 12500,
  parameter int RH_OFFSET   = 600,
  parameter bit RH_CLAMP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Temperature_Raw,
  input  logic [15:0] Humidity_Raw,
  input  logic        Temp_Ready_In,
  input  logic        RH_Ready_In,
  input  logic        CRC_Error_In,
  output logic [15:0] Temp_Centi,
  output logic [15:0] RH_Centi,
  output logic        Result_Valid,
  output logic        Busy,
  output logic [7:0]  CRC_Error_Count,
  output logic [15:0] Sample_Count
);

  typedef enum logic [1:0] {IDLE, MUL_T, MUL_RH, DONE} state_t;

  localparam logic signed [17:0] RH_OFF_S = 18'(RH_OFFSET);
  localparam logic signed [17:0] RH_MAX_S = 18'sd10000;

  state_t             state_q;
  logic               t_have_q, rh_have_q;
  logic [15:0]        t_raw_q, rh_raw_q;
  logic [31:0]        acc_q, mcand_q;
  logic [15:0]        mplier_q;
  logic [3:0]         iter_q;
  logic signed [15:0] t_res_q;
  logic [15:0]        rh_hi_q;
  logic [15:0]        temp_q, rh_q;
  logic               valid_q;
  logic [7:0]         crc_cnt_q;
  logic [15:0]        sample_cnt_q;

  logic [31:0]        acc_d;
  logic signed [15:0] t_calc_d;
  logic               t_have_d, rh_have_d;
  logic [15:0]        t_raw_d;

  // Offset removal and optional clamp of the humidity integer part.
  function automatic logic [15:0] rh_convert(input logic [15:0] hi);
    logic signed [17:0] v;
    v = $signed({2'b00, hi}) - RH_OFF_S;
    if (RH_CLAMP_EN) begin
      if (v < 18'sd0)
        v = 18'sd0;
      else if (v > RH_MAX_S)
        v = RH_MAX_S;
    end
    return v[15:0];
  endfunction

  // One shift-add step, temperature offset on the integer part, and the
  // capture flags as they would stand after this edge in IDLE.
  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    t_calc_d  = $signed(acc_d[31:16] - 16'(T_OFFSET));
    t_have_d  = t_have_q | Temp_Ready_In;
    rh_have_d = rh_have_q | RH_Ready_In;
    t_raw_d   = Temp_Ready_In ? Temperature_Raw : t_raw_q;
  end

  // Control FSM, multiplier datapath, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      t_have_q     <= 1'b0;
      rh_have_q    <= 1'b0;
      t_raw_q      <= '0;
      rh_raw_q     <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      iter_q       <= '0;
      t_res_q      <= '0;
      rh_hi_q      <= '0;
      temp_q       <= '0;
      rh_q         <= '0;
      valid_q      <= 1'b0;
      crc_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      // CRC errors are counted in every state; only IDLE treats them as an abort.
      if (CRC_Error_In && (crc_cnt_q != 8'hFF))
        crc_cnt_q <= crc_cnt_q + 8'd1;

      case (state_q)
        IDLE: begin
          if (CRC_Error_In) begin
            t_have_q  <= 1'b0;
            rh_have_q <= 1'b0;
          end else begin
            t_raw_q <= t_raw_d;
            if (RH_Ready_In)
              rh_raw_q <= Humidity_Raw;
            if (t_have_d && rh_have_d) begin
              t_have_q  <= 1'b0;
              rh_have_q <= 1'b0;
              acc_q     <= '0;
              mcand_q   <= 32'(T_SCALE);
              mplier_q  <= t_raw_d;
              iter_q    <= '0;
              state_q   <= MUL_T;
            end else begin
              t_have_q  <= t_have_d;
              rh_have_q <= rh_have_d;
            end
          end
        end

        MUL_T: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          iter_q   <= iter_q + 4'd1;
          if (iter_q == 4'd15) begin
            t_res_q  <= t_calc_d;
            acc_q    <= '0;
            mcand_q  <= 32'(RH_SCALE);
            mplier_q <= rh_raw_q;
            iter_q   <= '0;
            state_q  <= MUL_RH;
          end
        end

        MUL_RH: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          iter_q   <= iter_q + 4'd1;
          if (iter_q == 4'd15) begin
            rh_hi_q <= acc_d[31:16];
            state_q <= DONE;
          end
        end

        DONE: begin
          temp_q       <= t_res_q;
          rh_q         <= rh_convert(rh_hi_q);
          valid_q      <= 1'b1;
          sample_cnt_q <= sample_cnt_q + 16'd1;
          state_q      <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign Temp_Centi      = temp_q;
  assign RH_Centi        = rh_q;
  assign Result_Valid    = valid_q;
  assign Busy            = (state_q != IDLE);
  assign CRC_Error_Count = crc_cnt_q;
  assign Sample_Count    = sample_cnt_q;

endmodule

// File: tb/tb_sht40_result_converter.sv
// Bench for sht40_result_converter: fixed vectors, randomized pairs against an
// arithmetic reference, and hand-written abort/overwrite/busy/reset sequences.
module tb_sht40_result_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Temperature_Raw, Humidity_Raw;
  logic        Temp_Ready_In, RH_Ready_In, CRC_Error_In;
  logic [15:0] Temp_Centi, RH_Centi;
  logic        Result_Valid, Busy;
  logic [7:0]  CRC_Error_Count;
  logic [15:0] Sample_Count;

  int n_tests = 0;
  int n_fail  = 0;
  int samples = 0;
  int crc_exp = 0;

  always #5 clk = ~clk;

  sht40_result_converter dut (
    .clk(clk), .rst(rst),
    .Temperature_Raw(Temperature_Raw), .Humidity_Raw(Humidity_Raw),
    .Temp_Ready_In(Temp_Ready_In), .RH_Ready_In(RH_Ready_In),
    .CRC_Error_In(CRC_Error_In),
    .Temp_Centi(Temp_Centi), .RH_Centi(RH_Centi),
    .Result_Valid(Result_Valid), .Busy(Busy),
    .CRC_Error_Count(CRC_Error_Count), .Sample_Count(Sample_Count)
  );

  typedef struct {
    logic [15:0] t;
    logic [15:0] rh;
    int          exp_t;
    int          exp_rh;
  } vec_t;

  vec_t vecs[5];

  function automatic longint model_t(input logic [15:0] raw);
    longint r;
    r = raw;
    return (r * 17500) / 65536 - 4500;
  endfunction

  function automatic longint model_rh(input logic [15:0] raw);
    longint r, v;
    r = raw;
    v = (r * 12500) / 65536 - 600;
    if (v < 0) v = 0;
    if (v > 10000) v = 10000;
    return v;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic strobe(input bit dt, input bit drh, input logic [15:0] t,
                        input logic [15:0] rh, input bit crc);
    Temperature_Raw = t;
    Humidity_Raw    = rh;
    Temp_Ready_In   = dt;
    RH_Ready_In     = drh;
    CRC_Error_In    = crc;
    @(posedge clk); #1;
    Temp_Ready_In   = 1'b0;
    RH_Ready_In     = 1'b0;
    CRC_Error_In    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!Result_Valid && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (Result_Valid) seen++;
    end
    check(name, seen, 0);
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input longint et, input longint erh);
    check({name, " latency"}, lat, exp_lat);
    check({name, " temp"}, $signed(Temp_Centi), et);
    check({name, " rh"}, $signed(RH_Centi), erh);
    samples = (samples + 1) % 65536;
    check({name, " samples"}, Sample_Count, samples);
    idle(1);
    check({name, " valid pulse width"}, Result_Valid, 0);
  endtask

  task automatic convert(input string name, input logic [15:0] t, input logic [15:0] rh,
                         input longint et, input longint erh);
    int n;
    strobe(1'b1, 1'b1, t, rh, 1'b0);
    check({name, " busy"}, Busy, 1);
    wait_valid(n);
    check_result(name, n, 33, et, erh);
  endtask

  initial begin
    int n;
    logic [15:0] rt, rr;

    vecs[0] = '{16'h6666, 16'h8000, 2499, 5650};
    vecs[1] = '{16'h0000, 16'h0000, -4500, 0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 12999, 10000};
    vecs[3] = '{16'h4000, 16'h1000, -125, 181};
    vecs[4] = '{16'h8000, 16'hC000, 4250, 8775};

    rst = 1'b1;
    Temperature_Raw = '0; Humidity_Raw = '0;
    Temp_Ready_In = 1'b0; RH_Ready_In = 1'b0; CRC_Error_In = 1'b0;
    idle(3);
    check("reset temp", Temp_Centi, 0);
    check("reset rh", RH_Centi, 0);
    check("reset valid", Result_Valid, 0);
    check("reset busy", Busy, 0);
    check("reset crc", CRC_Error_Count, 0);
    check("reset samples", Sample_Count, 0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 5; i++)
      convert($sformatf("vec%0d", i), vecs[i].t, vecs[i].rh, vecs[i].exp_t, vecs[i].exp_rh);

    // Randomized pairs; some with the two strobes separated by a gap.
    for (int i = 0; i < 20; i++) begin
      rt = 16'($urandom_range(0, 65535));
      rr = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) begin
        strobe(1'b1, 1'b0, rt, 16'h0, 1'b0);
        idle($urandom_range(0, 3));
        strobe(1'b0, 1'b1, 16'h0, rr, 1'b0);
        wait_valid(n);
        check_result($sformatf("rand%0d split", i), n, 33, model_t(rt), model_rh(rr));
      end else begin
        convert($sformatf("rand%0d", i), rt, rr, model_t(rt), model_rh(rr));
      end
    end

    // CRC error discards a partial pair.
    strobe(1'b1, 1'b0, 16'h1234, 16'h0, 1'b0);
    idle(4);
    strobe(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    crc_exp++;
    strobe(1'b0, 1'b1, 16'h0, 16'h8000, 1'b0);
    watch_no_valid("crc abort no valid", 40);
    check("crc abort count", CRC_Error_Count, crc_exp);
    check("crc abort busy", Busy, 0);
    convert("after crc", 16'h6666, 16'h8000, 2499, 5650);

    // CRC coinciding with both strobes wins.
    strobe(1'b1, 1'b1, 16'h6666, 16'h8000, 1'b1);
    crc_exp++;
    watch_no_valid("crc vs strobe no valid", 40);
    check("crc vs strobe count", CRC_Error_Count, crc_exp);

    // Repeated temperature strobe overwrites the latch.
    strobe(1'b1, 1'b0, 16'h1111, 16'h0, 1'b0);
    idle(2);
    strobe(1'b1, 1'b0, 16'h6666, 16'h0, 1'b0);
    idle(1);
    strobe(1'b0, 1'b1, 16'h0, 16'h8000, 1'b0);
    wait_valid(n);
    check_result("overwrite", n, 33, 2499, 5650);

    // Pair and CRC while busy: pair ignored, CRC counted, no abort.
    strobe(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    idle(5);
    strobe(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0);
    strobe(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    crc_exp++;
    wait_valid(n);
    check_result("busy ignore", n, 26, 12999, 10000);
    check("busy crc count", CRC_Error_Count, crc_exp);
    watch_no_valid("busy ignore no second valid", 45);

    // Reset in the middle of the temperature multiply.
    strobe(1'b1, 1'b1, 16'h4000, 16'h1000, 1'b0);
    idle(9);
    rst = 1'b1;
    #1;
    check("midreset temp", Temp_Centi, 0);
    check("midreset rh", RH_Centi, 0);
    check("midreset busy", Busy, 0);
    check("midreset valid", Result_Valid, 0);
    check("midreset samples", Sample_Count, 0);
    check("midreset crc", CRC_Error_Count, 0);
    samples = 0;
    crc_exp = 0;
    @(posedge clk); #1;
    idle(1);
    rst = 1'b0;
    watch_no_valid("midreset no valid", 40);
    convert("after reset", 16'h6666, 16'h8000, 2499, 5650);

    // CRC counter saturation.
    repeat (254) strobe(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("crc 254", CRC_Error_Count, 254);
    repeat (2) strobe(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("crc saturate 256", CRC_Error_Count, 255);
    strobe(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("crc saturate hold", CRC_Error_Count, 255);
    convert("after saturate", 16'hFFFF, 16'h0000, 12999, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
